// File: rtl/bcd_serial_alu.sv
// ============================================================================
// Module   : bcd_serial_alu
// Brief    : Digit-serial packed-BCD adder/subtractor with ten's-complement fixup
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_serial_alu #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   result,
    output logic                   carry_sign,
    output logic                   err
);

    localparam int c_WIDTH = 4 * NDIGITS;
    localparam int c_IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_WIDTH-1:0]    r_a;
    logic [c_WIDTH-1:0]    r_b;
    logic [c_WIDTH-1:0]    r_acc;
    logic                  r_op;
    logic                  r_c;
    logic [c_IDX_W-1:0]    r_idx;

    logic                  w_bad;
    logic [3:0]            w_src;
    logic [3:0]            w_addend;
    logic [4:0]            w_t;
    logic [3:0]            w_dig;
    logic                  w_cout;
    logic [c_WIDTH-1:0]    w_acc_next;
    logic                  w_last;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    // One shared digit adder: CALC adds a_i + b'_i, COMP forms (9 - r_i) + c.
    always_comb begin
        if (r_state == COMP) begin
            w_src    = 4'd9 - r_acc[3:0];
            w_addend = 4'd0;
        end else begin
            w_src    = r_a[3:0];
            w_addend = r_op ? (4'd9 - r_b[3:0]) : r_b[3:0];
        end
        w_t = 5'(w_src) + 5'(w_addend) + 5'(r_c);
        if (w_t > 5'd9) begin
            w_dig  = 4'(w_t - 5'd10);
            w_cout = 1'b1;
        end else begin
            w_dig  = w_t[3:0];
            w_cout = 1'b0;
        end
        w_acc_next = (r_acc >> 4) | (c_WIDTH'(w_dig) << (4 * (NDIGITS - 1)));
        w_last     = (r_idx == c_LAST_IDX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_op       <= 1'b0;
            r_c        <= 1'b0;
            r_idx      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry_sign <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_op  <= op;
                        r_c   <= op;
                        r_idx <= '0;
                        r_acc <= '0;
                        busy  <= 1'b1;
                        if (w_bad) begin
                            result     <= '0;
                            carry_sign <= 1'b0;
                            err        <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_a   <= r_a >> 4;
                    r_b   <= r_b >> 4;
                    r_acc <= w_acc_next;
                    r_c   <= w_cout;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_idx <= '0;
                        // Subtract without final carry means A<B: negate the wrapped result.
                        if (r_op && !w_cout) begin
                            r_c     <= 1'b1;
                            r_state <= COMP;
                        end else begin
                            result     <= w_acc_next;
                            carry_sign <= r_op ? 1'b0 : w_cout;
                            err        <= 1'b0;
                            r_state    <= DONE;
                        end
                    end
                end
                COMP: begin
                    r_acc <= w_acc_next;
                    r_c   <= w_cout;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_idx      <= '0;
                        result     <= w_acc_next;
                        carry_sign <= 1'b1;
                        err        <= 1'b0;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_alu.sv
// ============================================================================
// Module   : tb_bcd_serial_alu
// Brief    : Directed self-checking bench for bcd_serial_alu (NDIGITS = 4)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_sign;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_serial_alu #(.NDIGITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_sign (carry_sign),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation and reports what came back plus edges-to-done (-1 on timeout).
    task automatic do_op(input logic i_op, input logic [15:0] i_a, input logic [15:0] i_b,
                         output logic [15:0] o_res, output logic o_cs, output logic o_err,
                         output int o_lat);
        @(negedge clk);
        op = i_op; a = i_a; b = i_b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        o_lat = -1; o_res = 'x; o_cs = 1'bx; o_err = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                o_lat = i; o_res = result; o_cs = carry_sign; o_err = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, result, carry_sign, err} !== 20'h0)
            $display("FAIL reset_outputs: got %h want 00000", {busy, done, result, carry_sign, err});
        else n_pass++;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_add();
        logic [15:0] r; logic cs; logic e; int lat;
        do_op(1'b0, 16'h0456, 16'h0789, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h1245, 1'b0, 1'b0} || lat != 5)
            $display("FAIL add_0456_0789: got r=%h cs=%b err=%b lat=%0d want r=1245 cs=0 err=0 lat=5", r, cs, e, lat);
        else n_pass++;
        do_op(1'b0, 16'h9999, 16'h0001, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0000, 1'b1, 1'b0} || lat != 5)
            $display("FAIL add_9999_0001: got r=%h cs=%b err=%b lat=%0d want r=0000 cs=1 err=0 lat=5", r, cs, e, lat);
        else n_pass++;
        do_op(1'b0, 16'h0005, 16'h0005, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0010, 1'b0, 1'b0})
            $display("FAIL add_5_5: got r=%h cs=%b err=%b want r=0010 cs=0 err=0", r, cs, e);
        else n_pass++;
        do_op(1'b0, 16'h5678, 16'h4444, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0122, 1'b1, 1'b0})
            $display("FAIL add_5678_4444: got r=%h cs=%b err=%b want r=0122 cs=1 err=0", r, cs, e);
        else n_pass++;
    endtask

    task automatic test_sub();
        logic [15:0] r; logic cs; logic e; int lat;
        do_op(1'b1, 16'h1000, 16'h0001, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0999, 1'b0, 1'b0} || lat != 5)
            $display("FAIL sub_1000_0001: got r=%h cs=%b err=%b lat=%0d want r=0999 cs=0 err=0 lat=5", r, cs, e, lat);
        else n_pass++;
        do_op(1'b1, 16'h0001, 16'h1000, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0999, 1'b1, 1'b0} || lat != 9)
            $display("FAIL sub_0001_1000: got r=%h cs=%b err=%b lat=%0d want r=0999 cs=1 err=0 lat=9", r, cs, e, lat);
        else n_pass++;
        do_op(1'b1, 16'h0123, 16'h0123, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0000, 1'b0, 1'b0} || lat != 5)
            $display("FAIL sub_equal: got r=%h cs=%b err=%b lat=%0d want r=0000 cs=0 err=0 lat=5", r, cs, e, lat);
        else n_pass++;
        do_op(1'b1, 16'h0050, 16'h0075, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0025, 1'b1, 1'b0} || lat != 9)
            $display("FAIL sub_0050_0075: got r=%h cs=%b err=%b lat=%0d want r=0025 cs=1 err=0 lat=9", r, cs, e, lat);
        else n_pass++;
    endtask

    task automatic test_invalid();
        logic [15:0] r; logic cs; logic e; int lat;
        do_op(1'b0, 16'h00A0, 16'h0001, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0000, 1'b0, 1'b1} || lat != 1)
            $display("FAIL invalid_a: got r=%h cs=%b err=%b lat=%0d want r=0000 cs=0 err=1 lat=1", r, cs, e, lat);
        else n_pass++;
        do_op(1'b1, 16'h0001, 16'hF000, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0000, 1'b0, 1'b1} || lat != 1)
            $display("FAIL invalid_b: got r=%h cs=%b err=%b lat=%0d want r=0000 cs=0 err=1 lat=1", r, cs, e, lat);
        else n_pass++;
        do_op(1'b0, 16'h0011, 16'h0022, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0033, 1'b0, 1'b0})
            $display("FAIL err_clears: got r=%h cs=%b err=%b want r=0033 cs=0 err=0", r, cs, e);
        else n_pass++;
    endtask

    task automatic test_busy_start();
        int n_done = 0;
        logic [15:0] r = '0;
        @(negedge clk);
        op = 1'b0; a = 16'h0456; b = 16'h0789; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_mid_calc: got %b want 1", busy);
        else n_pass++;
        op = 1'b1; a = 16'h9999; b = 16'h8888; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin n_done++; r = result; end
        end
        n_checks++;
        if (n_done != 1 || r !== 16'h1245)
            $display("FAIL ignore_start_busy: got dones=%0d r=%h want dones=1 r=1245", n_done, r);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] r; logic cs; logic e; int lat;
        do_op(1'b0, 16'h0100, 16'h0200, r, cs, e, lat);
        // done is high now; request the next operation in this same IDLE cycle
        op = 1'b1; a = 16'h0300; b = 16'h0100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_accept: got done=%b busy=%b want done=0 busy=1", done, busy);
        else n_pass++;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = i; r = result; cs = carry_sign; break; end
        end
        n_checks++;
        if (r !== 16'h0200 || cs !== 1'b0 || lat != 5)
            $display("FAIL b2b_result: got r=%h cs=%b lat=%0d want r=0200 cs=0 lat=5", r, cs, lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        logic [15:0] r; logic cs; logic e; int lat;
        @(negedge clk);
        op = 1'b0; a = 16'h0456; b = 16'h0789; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, result, carry_sign, err} !== 20'h0)
            $display("FAIL reset_async: got %h want 00000", {busy, done, result, carry_sign, err});
        else n_pass++;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        n_checks++;
        if (n_done != 0) $display("FAIL reset_no_done: got dones=%0d want 0", n_done);
        else n_pass++;
        do_op(1'b0, 16'h0001, 16'h0002, r, cs, e, lat);
        n_checks++;
        if ({r, cs, e} !== {16'h0003, 1'b0, 1'b0} || lat != 5)
            $display("FAIL after_reset_add: got r=%h cs=%b err=%b lat=%0d want r=0003 cs=0 err=0 lat=5", r, cs, e, lat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_invalid();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_serial_alu.md
BCD_SERIAL_ALU -- requirements
Module: bcd_serial_alu

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, giving the number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 1, operation select: 0 = A+B, 1 = A-B.
REQ-006 SHALL have port a, input, 4*NDIGITS, operand A as packed BCD, digit 0 in bits [3:0].
REQ-007 SHALL have port b, input, 4*NDIGITS, operand B as packed BCD, same packing.
REQ-008 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when result, carry_sign and err are valid.
REQ-010 SHALL have port result, output, 4*NDIGITS, packed BCD magnitude of the result.
REQ-011 SHALL have port carry_sign, output, 1, carry-out for add, or 1 when A<B for subtract.
REQ-012 SHALL have port err, output, 1, high when either latched operand held a digit greater than 9.

Function
REQ-013 SHALL implement the states IDLE, CALC, COMP and DONE.
REQ-014 SHALL, on start=1 in IDLE, latch a, b and op and reset the digit index to 0; the carry SHALL be preset to op.
REQ-015 SHALL, at the same latch, check both operands; if any digit is >9, go directly to DONE with result=0, carry_sign=0 and err=1.
REQ-016 SHALL, if the operands are valid, go to CALC and process one digit per cycle, least-significant first, for NDIGITS cycles.
REQ-017 SHALL, in CALC, compute t = a_i + b'_i + c, where b'_i = b_i for add and 9-b_i for subtract.
REQ-018 SHALL correct each CALC digit as follows: if t>9 then digit = t-10 and c=1; otherwise digit = t and c=0.
REQ-019 SHALL, after the last CALC digit of an add, set carry_sign = c and go to DONE.
REQ-020 SHALL, after the last CALC digit of a subtract, set carry_sign=0 and go to DONE if c=1; if c=0, set carry_sign=1 and go to COMP.
REQ-021 SHALL, in COMP, replace the intermediate result with its ten's complement over NDIGITS cycles, one digit per cycle, using digit = (9-r_i) + c with c preset to 1 and the same >9 correction.
REQ-022 SHALL update result, carry_sign and err only on entry to DONE, and hold them until the next DONE.
REQ-023 SHALL assert done for exactly one cycle in DONE and then return to IDLE.
REQ-024 SHALL meet the following latency, with start sampled at edge k:
- add, or subtract with A>=B: done high in the cycle after edge k+NDIGITS+1;
- subtract with A<B: done after edge k+2*NDIGITS+1;
- invalid operand: done after edge k+1.
REQ-025 SHALL ignore start while busy=1; operands applied during busy have no effect.
REQ-026 SHALL allow start to be accepted in the IDLE cycle immediately following DONE (back-to-back operation).
REQ-027 SHALL return result 0 with carry_sign 0 for A-B when A==B.
REQ-028 SHALL produce a BCD magnitude in result; a carry out of the top digit on add is reported only via carry_sign, with result wrapping modulo 10^NDIGITS.

Reset
REQ-029 SHALL, on reset=1, immediately force state=IDLE and busy=0, done=0, result=0, carry_sign=0, err=0, regardless of clk.
REQ-030 SHALL abort an operation on reset during CALC or COMP, emitting no done pulse; the first start after reset is released is accepted normally.

Verification (NDIGITS=4)
REQ-031 SHALL verify add 0456+0789: result=1245, carry_sign=0, err=0, done after edge k+5.
REQ-032 SHALL verify add 9999+0001: result=0000, carry_sign=1.
REQ-033 SHALL verify subtract 1000-0001: result=0999, carry_sign=0, done after edge k+5; and subtract 0001-1000: result=0999, carry_sign=1, done after edge k+9.
REQ-034 SHALL verify operand a=0x00A0: err=1, result=0, carry_sign=0, done after edge k+1.
REQ-035 SHALL verify that start pulsed with new operands mid-CALC is ignored: the result corresponds only to the first operands and exactly one done is produced.
REQ-036 SHALL verify reset asserted on CALC cycle 2: all outputs 0 immediately, no done pulse; a following add 0001+0002 returns 0003.
